tt_um_tdm_demux4: RTL and testbench



---
 rtl/tdm_sync_edge.sv | 35 +++
 rtl/tt_um_tdm_demux4.sv | 102 ++++++++++
 tb/tb_tt_um_tdm_demux4.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/tdm_sync_edge.sv
// Input conditioning for the slot-mux pins: SYNC_STAGES-deep synchronizer on a
// 3-bit bus {strobe, sync, data}, plus a registered rising-edge pulse on strobe.
module tdm_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] din,
    output logic       data,
    output logic       sync,
    output logic       rise
);

    logic [SYNC_STAGES-1:0][2:0] stg;
    logic                        strb_d;

    // data/sync are re-registered next to the rise pulse so all three describe the same sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg    <= '0;
            strb_d <= 1'b0;
            rise   <= 1'b0;
            data   <= 1'b0;
            sync   <= 1'b0;
        end else begin
            stg[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) stg[i] <= stg[i-1];
            strb_d <= stg[SYNC_STAGES-1][2];
            rise   <= stg[SYNC_STAGES-1][2] & ~strb_d;
            data   <= stg[SYNC_STAGES-1][0];
            sync   <= stg[SYNC_STAGES-1][1];
        end
    end

endmodule

// File: rtl/tt_um_tdm_demux4.sv
// Four-slot TDM demultiplexer: aligns to frame sync, collects slot bits in a
// shadow register and commits whole frames atomically; counts frames and sync errors.
module tt_um_tdm_demux4 #(
    parameter int SYNC_STAGES = 2,
    parameter int ERR_SAT     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    localparam int CLR_B   = 6;
    localparam int RDSEL_B = 7;

    logic [0:0] state;
    logic [1:0] slot_cnt;
    logic [2:0] shadow;
    logic [3:0] out_reg;
    logic [7:0] err_cnt;
    logic [7:0] frame_cnt;
    logic       frame_done;
    logic       sync_err;

    logic s_data, s_sync, ev;
    logic err_ev;
    logic unused;

    tdm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ui_in[2:0]),
        .data  (s_data),
        .sync  (s_sync),
        .rise  (ev)
    );

    // early sync (slot_cnt!=0) or missed sync (slot_cnt==0) while locked
    always_comb begin
        err_ev = 1'b0;
        if (ena && ev && state == LOCKED)
            err_ev = s_sync ? (slot_cnt != 2'd0) : (slot_cnt == 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            slot_cnt   <= 2'd0;
            shadow     <= 3'd0;
            out_reg    <= 4'd0;
            err_cnt    <= 8'd0;
            frame_cnt  <= 8'd0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            sync_err   <= err_ev;
            if (ena) begin
                // clear takes priority over a coincident error
                if (ui_in[CLR_B])
                    err_cnt <= 8'd0;
                else if (err_ev && (ERR_SAT == 0 || err_cnt != 8'hFF))
                    err_cnt <= err_cnt + 8'd1;

                if (ev) begin
                    if (s_sync) begin
                        // frame start, initial lock, or realign after early sync
                        shadow[0] <= s_data;
                        slot_cnt  <= 2'd1;
                        state     <= LOCKED;
                    end else if (state == LOCKED) begin
                        if (slot_cnt == 2'd0) begin
                            state <= HUNT;
                        end else if (slot_cnt == 2'd3) begin
                            out_reg    <= {s_data, shadow};
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 8'd1;
                            slot_cnt   <= 2'd0;
                        end else begin
                            shadow[slot_cnt] <= s_data;
                            slot_cnt         <= slot_cnt + 2'd1;
                        end
                    end
                end
            end
        end
    end

    assign uo_out  = {sync_err & ena, frame_done & ena, state == LOCKED,
                      out_reg[ui_in[5:4]], out_reg};
    assign uio_out = ui_in[RDSEL_B] ? frame_cnt : err_cnt;
    assign uio_oe  = 8'hFF;
    assign unused  = &{1'b0, ui_in[3], uio_in};

endmodule

// File: tb/tb_tt_um_tdm_demux4.sv
// Directed bench for tt_um_tdm_demux4 with a frame-level behavioural model
// checked every cycle, plus literal expectations at key points.
module tb_tt_um_tdm_demux4;

    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    tt_um_tdm_demux4 #(.SYNC_STAGES(SS), .ERR_SAT(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t;
        bit s;
        bit d;
    } ev_t;

    ev_t evq[$];
    int  cyc = 0;
    int  n_chk = 0, n_pass = 0, n_fail = 0;
    bit  chk_on = 1'b0;

    // frame-level model
    bit         m_locked;
    int         m_slot;
    bit         m_sh[3];
    logic [3:0] m_out;
    int         m_err, m_frames;
    bit         m_fd, m_se;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_slot = 0; m_out = 4'h0; m_err = 0; m_frames = 0;
        m_fd = 0; m_se = 0;
        for (int i = 0; i < 3; i++) m_sh[i] = 0;
    endtask

    task automatic model_err();
        m_se = 1;
        m_err = (m_err >= 255) ? 255 : m_err + 1;
    endtask

    task automatic model_apply(input bit s, input bit d);
        if (s) begin
            if (m_locked && m_slot != 0) model_err();
            m_sh[0] = d; m_slot = 1; m_locked = 1;
        end else if (m_locked) begin
            if (m_slot == 0) begin
                model_err(); m_locked = 0;
            end else if (m_slot == 3) begin
                m_out = {d, m_sh[2], m_sh[1], m_sh[0]};
                m_fd = 1; m_frames = (m_frames + 1) % 256; m_slot = 0;
            end else begin
                m_sh[m_slot] = d; m_slot = m_slot + 1;
            end
        end
    endtask

    // model clock: pulses last one cycle; events take effect when they mature
    initial begin
        ev_t e;
        forever begin
            @(posedge clk);
            cyc++;
            m_fd = 0; m_se = 0;
            if (rst_n) begin
                while (evq.size() > 0 && evq[0].t <= cyc) begin
                    e = evq.pop_front();
                    if (e.t == cyc && ena) model_apply(e.s, e.d);
                end
                if (ena && ui_in[6]) m_err = 0;
            end
        end
    end

    initial begin
        logic [7:0] exp_uo, exp_uio;
        forever begin
            @(negedge clk); #2;
            if (chk_on) begin
                exp_uo  = {m_se & ena, m_fd & ena, m_locked, m_out[ui_in[5:4]], m_out};
                exp_uio = ui_in[7] ? 8'(m_frames) : 8'(m_err);
                check("cyc uo_out", uo_out, exp_uo);
                check("cyc uio_out", uio_out, exp_uio);
            end
        end
    end

    // one strobe pulse carrying (sync,data); effect lands SS+2 clocks after the pins change
    task automatic drive(input bit s, input bit d, input int hi, input int lo);
        ev_t e;
        @(negedge clk);
        ui_in[0] = d; ui_in[1] = s; ui_in[2] = 1'b1;
        e.t = cyc + SS + 2; e.s = s; e.d = d;
        evq.push_back(e);
        repeat (hi) @(negedge clk);
        ui_in[2] = 1'b0;
        repeat (lo - 1) @(negedge clk);
    endtask

    task automatic ev(input bit s, input bit d);
        drive(s, d, 2, 2);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic sweep(input string tag, input logic [3:0] exp);
        for (int i = 0; i < 4; i++) begin
            ui_in[5:4] = 2'(i);
            #1;
            check({tag, " monitor"}, 8'(uo_out[4]), 8'(exp[i]));
        end
    endtask

    initial begin
        ena = 1'b1; uio_in = 8'h5A;
        model_reset();
        settle(3);
        check("reset uo_out", uo_out, 8'h00);
        check("reset uio_out", uio_out, 8'h00);
        check("uio_oe", uio_oe, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1; chk_on = 1'b1;
        sweep("pre-frame", 4'b0000);

        // clean frame -> 4'hD
        ev(1, 1); ev(0, 0); ev(0, 1); ev(0, 1);
        settle(1);
        check("frame1 channels", 8'(uo_out[3:0]), 8'h0D);
        check("frame1 done", 8'(uo_out[6]), 8'h01);
        check("frame1 locked", 8'(uo_out[5]), 8'h01);
        ui_in[7] = 1'b1; #1;
        check("frame_cnt", uio_out, 8'h01);
        ui_in[7] = 1'b0;
        sweep("post-frame", 4'b1101);

        // early sync, then realigned frame -> 4'hE
        ev(1, 0); ev(0, 1); ev(1, 0);
        settle(1);
        check("early sync_err", 8'(uo_out[7]), 8'h01);
        check("early err_cnt", uio_out, 8'h01);
        check("early out held", 8'(uo_out[3:0]), 8'h0D);
        ev(0, 1); ev(0, 1); ev(0, 1);
        settle(1);
        check("realign channels", 8'(uo_out[3:0]), 8'h0E);

        // missed sync
        ev(1, 0); ev(0, 0); ev(0, 0); ev(0, 0);
        ev(0, 1);
        settle(1);
        check("missed sync_err", 8'(uo_out[7]), 8'h01);
        check("missed unlocked", 8'(uo_out[5]), 8'h00);
        check("missed err_cnt", uio_out, 8'h02);
        ev(0, 1); ev(0, 0);
        settle(1);
        check("hunt ignores", 8'(uo_out[5]), 8'h00);
        ui_in[6] = 1'b1;
        @(negedge clk);
        ui_in[6] = 1'b0;
        #2;
        check("err clear", uio_out, 8'h00);

        // ena=0 during slots 1..3
        ev(1, 1);
        @(negedge clk); ena = 1'b0;
        ev(0, 0); ev(0, 0); ev(0, 0);
        settle(1);
        check("ena0 no commit", 8'(uo_out[3:0]), 8'h00);
        ena = 1'b1;
        ev(0, 1); ev(0, 0); ev(0, 1);
        settle(1);
        check("ena resume channels", 8'(uo_out[3:0]), 8'h0B);
        check("ena resume done", 8'(uo_out[6]), 8'h01);

        // back-to-back events every 2 clocks -> 4'h6
        drive(1, 0, 1, 1); drive(0, 1, 1, 1); drive(0, 1, 1, 1); drive(0, 0, 1, 1);
        settle(SS + 1);
        check("fast channels", 8'(uo_out[3:0]), 8'h06);
        check("fast done", 8'(uo_out[6]), 8'h01);

        // reset mid-frame
        ev(1, 1); ev(0, 1);
        @(negedge clk);
        rst_n = 1'b0; ui_in[7] = 1'b1;
        model_reset(); evq.delete();
        #2;
        check("midreset uo_out", uo_out, 8'h00);
        check("midreset frame_cnt", uio_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1; ui_in[7] = 1'b0;
        ev(1, 0); ev(0, 1); ev(0, 0); ev(0, 1);
        settle(1);
        check("post-reset channels", 8'(uo_out[3:0]), 8'h0A);

        // 257 early syncs: counter saturates
        for (int i = 0; i < 258; i++) drive(1, 0, 1, 1);
        settle(SS + 1);
        check("err saturate", uio_out, 8'hFF);

        settle(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
